// File: rtl/axi_read_intf.sv
`timescale 1ns/1ps
// AXI4 read-channel subordinate: one AR burst at a time, FIXED/INCR/WRAP address
// generation, 1-cycle-latency SRAM reads and a 2-entry R buffer for RREADY stalls.
module axi_read_intf #(
  parameter int unsigned ARID_WIDTH   = 4,
  parameter int unsigned ARADDR_WIDTH = 11,
  parameter int unsigned RDATA_WIDTH  = 32,
  parameter int unsigned MEM_AW       = ARADDR_WIDTH - $clog2(RDATA_WIDTH / 8)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ARID_WIDTH-1:0]   ARID,
  input  logic [ARADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [ARID_WIDTH-1:0]   RID,
  output logic [RDATA_WIDTH-1:0]  RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic                    mem_rd_en,
  output logic [MEM_AW-1:0]       mem_rd_addr,
  input  logic [RDATA_WIDTH-1:0]  mem_rd_data
);

  localparam int unsigned NB    = RDATA_WIDTH / 8;
  localparam int unsigned NB_LG = $clog2(NB);
  localparam int unsigned AW    = ARADDR_WIDTH;
  localparam int unsigned CW    = 9;

  typedef enum logic {IDLE, BURST} state_e;

  state_e                 state_q;
  logic                   arready_q;
  logic [ARID_WIDTH-1:0]  id_q;
  logic [AW-1:0]          addr_q;
  logic [7:0]             len_q;
  logic [2:0]             size_q;
  logic [1:0]             burst_q;
  logic                   err_q;
  logic [CW-1:0]          issue_cnt_q;
  logic [CW-1:0]          ret_cnt_q;
  logic                   inflight_q;
  logic [RDATA_WIDTH-1:0] fifo_q [2];
  logic                   wr_ptr_q;
  logic                   rd_ptr_q;
  logic [1:0]             count_q;

  logic                   ar_hs;
  logic                   req_err;
  logic [AW-1:0]          step;
  logic [AW-1:0]          len_bytes;
  logic [AW-1:0]          wrap_mask;
  logic [AW-1:0]          addr_d;
  logic                   fifo_empty;
  logic                   rvalid;
  logic                   r_hs;
  logic                   fifo_pop;
  logic                   push_mem;
  logic                   push_err;
  logic                   push;
  logic                   issue;
  logic [1:0]             occ;
  logic [RDATA_WIDTH-1:0] push_data;

  assign ar_hs = arready_q && ARVALID;

  // Request legality, evaluated on the incoming AR fields at capture
  always_comb begin
    req_err = 1'b0;
    if (ARSIZE > 3'(NB_LG)) req_err = 1'b1;
    if (ARBURST == 2'b11) req_err = 1'b1;
    if (ARBURST == 2'b10) begin
      if (!(ARLEN == 8'd1 || ARLEN == 8'd3 || ARLEN == 8'd7 || ARLEN == 8'd15)) req_err = 1'b1;
      if ((ARADDR & ((AW'(1) << ARSIZE) - AW'(1))) != '0) req_err = 1'b1;
    end
  end

  // Next beat address
  always_comb begin
    step      = AW'(1) << size_q;
    len_bytes = (AW'(len_q) + AW'(1)) << size_q;
    wrap_mask = len_bytes - AW'(1);
    addr_d    = addr_q + step;
    case (burst_q)
      2'b00:   addr_d = addr_q;
      2'b10:   addr_d = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default: addr_d = addr_q + step;
    endcase
  end

  // An in-flight read is presented directly when the buffer is empty, so the
  // first beat is visible in the cycle the memory returns it.
  assign fifo_empty = (count_q == 2'd0);
  assign rvalid     = !fifo_empty || inflight_q;
  assign r_hs       = rvalid && RREADY;
  assign fifo_pop   = !fifo_empty && RREADY;
  assign push_mem   = inflight_q && !(fifo_empty && RREADY);
  assign occ        = count_q + 2'(inflight_q);
  assign issue      = (state_q == BURST) && !err_q && (issue_cnt_q != '0) && (occ < 2'd2);
  assign push_err   = (state_q == BURST) && err_q && (issue_cnt_q != '0) && (count_q < 2'd2);
  assign push       = push_mem || push_err;
  assign push_data  = push_mem ? mem_rd_data : '0;

  assign ARREADY     = arready_q;
  assign RVALID      = rvalid;
  assign RID         = id_q;
  assign RDATA       = !fifo_empty ? fifo_q[rd_ptr_q] : (inflight_q ? mem_rd_data : '0);
  assign RRESP       = (rvalid && err_q) ? 2'b10 : 2'b00;
  assign RLAST       = rvalid && (ret_cnt_q == CW'(1));
  assign mem_rd_en   = issue;
  assign mem_rd_addr = addr_q[AW-1:NB_LG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      arready_q   <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      err_q       <= 1'b0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            arready_q   <= 1'b0;
            state_q     <= BURST;
            id_q        <= ARID;
            addr_q      <= ARADDR;
            len_q       <= ARLEN;
            size_q      <= ARSIZE;
            burst_q     <= ARBURST;
            err_q       <= req_err;
            issue_cnt_q <= CW'(ARLEN) + CW'(1);
            ret_cnt_q   <= CW'(ARLEN) + CW'(1);
          end
        end
        BURST: begin
          if (issue || push_err) issue_cnt_q <= issue_cnt_q - CW'(1);
          if (issue) addr_q <= addr_d;
          if (r_hs) begin
            ret_cnt_q <= ret_cnt_q - CW'(1);
            if (ret_cnt_q == CW'(1)) begin
              state_q   <= IDLE;
              arready_q <= 1'b1;
            end
          end
        end
      endcase
      inflight_q <= issue;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (fifo_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push) - 2'(fifo_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: tb/tb_axi_read_intf.sv
`timescale 1ns/1ps
// Directed bench for axi_read_intf: burst types, backpressure, error bursts,
// address-space boundaries and mid-burst reset against hand-derived beats.
module tb_axi_read_intf;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ARID;
  logic [10:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        mem_rd_en;
  logic [8:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi_read_intf dut (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  function automatic logic [31:0] mword(input logic [8:0] w);
    return 32'hD000_0000 + 32'(w) * 32'h0001_0001;
  endfunction

  // Synchronous SRAM model, one cycle of read latency
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mword(mem_rd_addr);

  logic [31:0] b_data[$];
  logic [1:0]  b_resp[$];
  logic        b_last[$];
  logic [3:0]  b_id[$];
  int          b_cyc[$];
  logic [8:0]  a_word[$];
  int          a_cyc[$];
  int          max_pend;
  int          stall_bad;
  bit          burst_done;

  // Issues one AR and records every read strobe and R handshake by cycle offset
  task automatic run_burst(input logic [3:0] id, input logic [10:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit bp,
                           input int budget);
    int issued, hs, wcyc;
    bit prev_stall;
    logic [31:0] prev_data;
    logic [1:0] prev_resp;
    logic prev_last;
    b_data.delete(); b_resp.delete(); b_last.delete(); b_id.delete(); b_cyc.delete();
    a_word.delete(); a_cyc.delete();
    max_pend = 0; stall_bad = 0; burst_done = 0;
    issued = 0; hs = 0; prev_stall = 0; prev_data = '0; prev_resp = '0; prev_last = 1'b0;
    @(negedge clk);
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
    ARVALID = 1'b1; RREADY = 1'b1;
    wcyc = 0;
    while (!ARREADY && wcyc < 20) begin
      @(negedge clk);
      wcyc++;
    end
    if (!ARREADY) begin
      ARVALID = 1'b0;
      return;
    end
    for (int k = 1; k <= budget && !burst_done; k++) begin
      @(negedge clk);
      ARVALID = 1'b0;
      RREADY = bp ? ((k % 3) == 2) : 1'b1;
      #1;
      if (mem_rd_en) begin
        a_word.push_back(mem_rd_addr);
        a_cyc.push_back(k);
        issued++;
      end
      if (issued - hs > max_pend) max_pend = issued - hs;
      if (prev_stall && (!RVALID || RDATA !== prev_data || RRESP !== prev_resp || RLAST !== prev_last))
        stall_bad++;
      prev_stall = RVALID && !RREADY;
      prev_data = RDATA; prev_resp = RRESP; prev_last = RLAST;
      if (RVALID && RREADY) begin
        b_data.push_back(RDATA); b_resp.push_back(RRESP); b_last.push_back(RLAST);
        b_id.push_back(RID); b_cyc.push_back(k);
        hs++;
        if (RLAST) burst_done = 1;
      end
    end
    @(negedge clk);
    RREADY = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (ARREADY !== 1'b0 || RVALID !== 1'b0 || RLAST !== 1'b0 || mem_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: arready=%b rvalid=%b rlast=%b rd_en=%b, want all 0", ARREADY, RVALID, RLAST, mem_rd_en);
    end
    n_cmp++;
    if (RID !== 4'h0 || RDATA !== 32'h0 || RRESP !== 2'b00 || mem_rd_addr !== 9'h0) begin
      n_fail++;
      $display("FAIL reset_data: rid=%h rdata=%h rresp=%b rd_addr=%h, want all 0", RID, RDATA, RRESP, mem_rd_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ARREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_arready: got %b want 1", ARREADY);
    end
  endtask

  task automatic test_incr();
    run_burst(4'h3, 11'h010, 8'd3, 3'd2, 2'b01, 1'b0, 20);
    n_cmp++;
    if (burst_done !== 1'b1 || b_data.size() != 4 || a_word.size() != 4) begin
      n_fail++;
      $display("FAIL incr_count: done=%0d beats=%0d reads=%0d, want 1/4/4", burst_done, b_data.size(), a_word.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        logic el;
        el = (i == 3);
        n_cmp++;
        if (a_word[i] !== 9'(4 + i) || a_cyc[i] != i + 1) begin
          n_fail++;
          $display("FAIL incr_read%0d: word=%0d cyc=%0d, want word=%0d cyc=%0d", i, a_word[i], a_cyc[i], 4 + i, i + 1);
        end
        n_cmp++;
        if (b_data[i] !== mword(9'(4 + i)) || b_resp[i] !== 2'b00 || b_last[i] !== el || b_cyc[i] != i + 2 || b_id[i] !== 4'h3) begin
          n_fail++;
          $display("FAIL incr_beat%0d: data=%h resp=%b last=%b cyc=%0d id=%h, want %h 00 %b %0d 3",
                   i, b_data[i], b_resp[i], b_last[i], b_cyc[i], b_id[i], mword(9'(4 + i)), el, i + 2);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [8:0] ew [4];
    ew[0] = 9'd7; ew[1] = 9'd4; ew[2] = 9'd5; ew[3] = 9'd6;
    run_burst(4'hA, 11'h01C, 8'd3, 3'd2, 2'b10, 1'b0, 20);
    n_cmp++;
    if (burst_done !== 1'b1 || b_data.size() != 4 || a_word.size() != 4) begin
      n_fail++;
      $display("FAIL wrap_count: done=%0d beats=%0d reads=%0d, want 1/4/4", burst_done, b_data.size(), a_word.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        logic el;
        el = (i == 3);
        n_cmp++;
        if (a_word[i] !== ew[i] || b_data[i] !== mword(ew[i]) || b_id[i] !== 4'hA || b_last[i] !== el || b_resp[i] !== 2'b00) begin
          n_fail++;
          $display("FAIL wrap_beat%0d: word=%0d data=%h id=%h last=%b resp=%b, want word=%0d data=%h id=a last=%b resp=00",
                   i, a_word[i], b_data[i], b_id[i], b_last[i], b_resp[i], ew[i], mword(ew[i]), el);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    run_burst(4'h5, 11'h040, 8'd7, 3'd2, 2'b01, 1'b1, 80);
    n_cmp++;
    if (burst_done !== 1'b1 || b_data.size() != 8 || a_word.size() != 8) begin
      n_fail++;
      $display("FAIL bp_count: done=%0d beats=%0d reads=%0d, want 1/8/8", burst_done, b_data.size(), a_word.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        logic el;
        el = (i == 7);
        n_cmp++;
        if (b_data[i] !== mword(9'(16 + i)) || b_last[i] !== el || b_resp[i] !== 2'b00) begin
          n_fail++;
          $display("FAIL bp_beat%0d: data=%h last=%b resp=%b, want %h %b 00", i, b_data[i], b_last[i], b_resp[i], mword(9'(16 + i)), el);
        end
      end
    end
    n_cmp++;
    if (stall_bad != 0) begin
      n_fail++;
      $display("FAIL bp_stable: %0d unstable stall cycles, want 0", stall_bad);
    end
    n_cmp++;
    if (max_pend > 2) begin
      n_fail++;
      $display("FAIL bp_outstanding: max %0d, want <= 2", max_pend);
    end
  endtask

  task automatic test_errors();
    logic [7:0] el_len [3];
    logic [2:0] el_size [3];
    logic [1:0] el_burst [3];
    el_len[0] = 8'd1; el_size[0] = 3'd3; el_burst[0] = 2'b01;
    el_len[1] = 8'd2; el_size[1] = 3'd2; el_burst[1] = 2'b11;
    el_len[2] = 8'd2; el_size[2] = 3'd2; el_burst[2] = 2'b10;
    for (int c = 0; c < 3; c++) begin
      int nb;
      nb = int'(el_len[c]) + 1;
      run_burst(4'(c + 1), 11'h000, el_len[c], el_size[c], el_burst[c], 1'b0, 20);
      n_cmp++;
      if (burst_done !== 1'b1 || b_data.size() != nb || a_word.size() != 0) begin
        n_fail++;
        $display("FAIL err%0d_count: done=%0d beats=%0d reads=%0d, want 1/%0d/0", c, burst_done, b_data.size(), a_word.size(), nb);
      end else begin
        for (int i = 0; i < nb; i++) begin
          logic el;
          el = (i == nb - 1);
          n_cmp++;
          if (b_resp[i] !== 2'b10 || b_data[i] !== 32'h0 || b_last[i] !== el) begin
            n_fail++;
            $display("FAIL err%0d_beat%0d: resp=%b data=%h last=%b, want 10 0 %b", c, i, b_resp[i], b_data[i], b_last[i], el);
          end
        end
      end
    end
  endtask

  task automatic test_boundary();
    run_burst(4'h4, 11'h7FC, 8'd2, 3'd2, 2'b00, 1'b0, 20);
    n_cmp++;
    if (burst_done !== 1'b1 || b_data.size() != 3 || a_word.size() != 3) begin
      n_fail++;
      $display("FAIL fixed_count: done=%0d beats=%0d reads=%0d, want 1/3/3", burst_done, b_data.size(), a_word.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (a_word[i] !== 9'd511 || b_data[i] !== mword(9'd511)) begin
          n_fail++;
          $display("FAIL fixed_beat%0d: word=%0d data=%h, want 511 %h", i, a_word[i], b_data[i], mword(9'd511));
        end
      end
    end
    run_burst(4'h4, 11'h7FC, 8'd1, 3'd2, 2'b01, 1'b0, 20);
    n_cmp++;
    if (burst_done !== 1'b1 || b_data.size() != 2 || a_word.size() != 2) begin
      n_fail++;
      $display("FAIL incr_wrap_count: done=%0d beats=%0d reads=%0d, want 1/2/2", burst_done, b_data.size(), a_word.size());
    end else begin
      n_cmp++;
      if (a_word[0] !== 9'd511 || a_word[1] !== 9'd0 || b_data[0] !== mword(9'd511) || b_data[1] !== mword(9'd0) || b_last[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL incr_wrap_beats: words=%0d,%0d data=%h,%h last=%b, want 511,0 %h,%h 1",
                 a_word[0], a_word[1], b_data[0], b_data[1], b_last[1], mword(9'd511), mword(9'd0));
      end
    end
  endtask

  task automatic test_reset_midburst();
    int hs, wcyc;
    @(negedge clk);
    ARID = 4'h6; ARADDR = 11'h080; ARLEN = 8'd7; ARSIZE = 3'd2; ARBURST = 2'b01;
    ARVALID = 1'b1; RREADY = 1'b1;
    wcyc = 0;
    while (!ARREADY && wcyc < 20) begin
      @(negedge clk);
      wcyc++;
    end
    hs = 0;
    wcyc = 0;
    while (hs < 2 && wcyc < 20) begin
      @(negedge clk);
      ARVALID = 1'b0;
      #1;
      if (RVALID && RREADY) hs++;
      wcyc++;
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (hs != 2 || RVALID !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: handshakes=%0d rvalid=%b, want 2 1", hs, RVALID);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (RVALID !== 1'b0 || RLAST !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async_rvalid: rvalid=%b rlast=%b, want 0 0", RVALID, RLAST);
    end
    @(negedge clk);
    n_cmp++;
    if (ARREADY !== 1'b0 || mem_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_hold: arready=%b rd_en=%b, want 0 0", ARREADY, mem_rd_en);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release: arready=%b rvalid=%b, want 1 0", ARREADY, RVALID);
    end
    run_burst(4'h7, 11'h020, 8'd0, 3'd2, 2'b01, 1'b0, 20);
    n_cmp++;
    if (burst_done !== 1'b1 || b_data.size() != 1 || a_word.size() != 1) begin
      n_fail++;
      $display("FAIL single_count: done=%0d beats=%0d reads=%0d, want 1/1/1", burst_done, b_data.size(), a_word.size());
    end else begin
      n_cmp++;
      if (a_word[0] !== 9'd8 || b_data[0] !== mword(9'd8) || b_last[0] !== 1'b1 || b_resp[0] !== 2'b00 || b_id[0] !== 4'h7 || b_cyc[0] != 2) begin
        n_fail++;
        $display("FAIL single_beat: word=%0d data=%h last=%b resp=%b id=%h cyc=%0d, want 8 %h 1 00 7 2",
                 a_word[0], b_data[0], b_last[0], b_resp[0], b_id[0], b_cyc[0], mword(9'd8));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
    ARVALID = 1'b0; RREADY = 1'b0;
    test_reset();
    test_incr();
    test_wrap();
    test_backpressure();
    test_errors();
    test_boundary();
    test_reset_midburst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
